// File: rtl/ir_fetch_sequencer_if.sv
// Instruction-memory and execute-datapath handshake bundle for the
// ir_fetch_sequencer.
//   mem_req/mem_addr/mem_ack : instruction fetch request, address and data-valid
//   load_ir                  : IR capture strobe, coincident with mem_ack
//   exec_start/exec_done     : launch and completion of one instruction
//   branch_taken/target      : redirect info, valid together with exec_done
// master = sequencer side, slave = memory/datapath side.
interface ir_fetch_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        load_ir;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output mem_req, mem_addr, load_ir, exec_start,
    input  mem_ack, exec_done, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, load_ir, exec_start,
    output mem_ack, exec_done, branch_taken, branch_target
  );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// Multicycle fetch/dispatch controller for the MIPS32 core. Owns the PC,
// fetches one instruction, strobes it into the IR, launches execution, waits
// for completion and then advances the PC sequentially or to a branch target.
// Handles halt requests at instruction boundaries, fetch timeout and
// misaligned branch targets (the latter two end in an absorbing FAULT state).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin/resume, honoured only in IDLE or HALTED
//   halt_req    : stop at the next instruction boundary
//   bus         : memory/execute handshake (master modport)
//   pc          : current instruction address (mem_addr mirrors it)
//   instr_count : retired instruction count, wraps at 2^32
//   busy/halted/fault/state : status and debug state encoding
module ir_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       halt_req,
  ir_fetch_sequencer_if.master       bus,
  output logic [31:0]                pc,
  output logic [31:0]                instr_count,
  output logic                       busy,
  output logic                       halted,
  output logic                       fault,
  output logic [2:0]                 state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_HALTED   = 3'd4,
    S_FAULT    = 3'd5
  } state_e;

  // Counter value seen during the last permitted FETCH cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        halt_q, halt_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        busy_w;
  logic        mem_req_w;
  logic        load_ir_w;
  logic        exec_start_w;

  assign busy_w = (state_q == S_FETCH) || (state_q == S_DISPATCH) ||
                  (state_q == S_WAIT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    halt_d       = halt_q;
    tmo_d        = 8'd0;
    mem_req_w    = 1'b0;
    load_ir_w    = 1'b0;
    exec_start_w = 1'b0;

    if (busy_w && halt_req) halt_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_w = 1'b1;
        if (bus.mem_ack) begin
          // Ack in the final allowed cycle still wins over the timeout.
          load_ir_w = 1'b1;
          state_d   = S_DISPATCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DISPATCH: begin
        exec_start_w = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.exec_done) begin
          // The instruction retires even when its branch target faults.
          cnt_d = cnt_q + 32'd1;
          if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
            state_d = S_FAULT;
          end else begin
            pc_d = bus.branch_taken ? bus.branch_target : (pc_q + 32'd4);
            // A halt_req arriving with exec_done applies to this boundary.
            if (halt_q || halt_req) begin
              state_d = S_HALTED;
              halt_d  = 1'b0;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          // Resume anyway, but stop again after the next instruction.
          if (halt_req) halt_d = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      halt_q  <= 1'b0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.mem_req    = mem_req_w;
  assign bus.mem_addr   = pc_q;
  assign bus.load_ir    = load_ir_w;
  assign bus.exec_start = exec_start_w;

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = busy_w;
  assign halted      = (state_q == S_HALTED);
  assign fault       = (state_q == S_FAULT);
  assign state       = state_q;

endmodule
